// File: rtl/mmio_uart_tx_pkg.sv
// Register map, bit positions and TX state encoding shared by the UART transmitter files.
// Pure declarations; no logic, no latency.
package mmio_uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_CNT_LSB   = 8;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_FLUSH_BIT   = 1;
    localparam int CTRL_OVF_CLR_BIT = 2;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Processor data-port slice seen by the UART: store/load strobes in, load data and window hit out.
// Read data and sel are combinational from the address; no handshake, stores always accepted.
interface mmio_uart_tx_if;
    logic        memwrite;
    logic        memread;
    logic [31:0] data_address;
    logic [31:0] writedata;
    logic [31:0] received_data;
    logic        sel;

    modport master (
        output memwrite, memread, data_address, writedata,
        input  received_data, sel
    );

    modport slave (
        input  memwrite, memread, data_address, writedata,
        output received_data, sel
    );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with flush; head word readable combinationally, push/pop take effect at the edge.
// A push when full or a pop when empty is ignored; flush wins over a same-edge push or pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full && !flush;
        do_pop   = pop && !empty && !flush;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window, FIFO-buffered, LSB first on tx.
// Store into empty idle FIFO starts the frame one edge later; stores to a full FIFO are dropped and flagged.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1001_0100,
    parameter int          BAUD_DIV   = 434,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    mmio_uart_tx_if.slave bus,
    output logic         tx
);
    localparam int          CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(BAUD_DIV - 1);

    logic [3:0]    offset;
    logic          hit, wr_tx, wr_ctrl;
    logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          unused_bits;

    tx_state_e   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        enable_q, enable_d;
    logic        ovf_q, ovf_d;
    logic        bit_tick;
    logic [31:0] status;

    assign offset      = bus.data_address[3:0];
    assign hit         = (bus.data_address[31:4] == BASE_ADDR[31:4]) &&
                         (offset == OFF_TXDATA || offset == OFF_STATUS || offset == OFF_CTRL);
    assign wr_tx       = bus.memwrite && hit && (offset == OFF_TXDATA);
    assign wr_ctrl     = bus.memwrite && hit && (offset == OFF_CTRL);
    assign fifo_push   = wr_tx && !fifo_full;
    assign fifo_flush  = wr_ctrl && bus.writedata[CTRL_FLUSH_BIT];
    assign bit_tick    = (baud_cnt_q == '0);
    assign tx          = tx_q;
    assign unused_bits = ^{bus.memread, bus.writedata[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (bus.writedata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Overflow keys off full before any same-edge pop, so a racing push is still lost.
    always_comb begin
        enable_d = enable_q;
        ovf_d    = ovf_q;
        if (wr_ctrl) begin
            enable_d = bus.writedata[CTRL_EN_BIT];
            if (bus.writedata[CTRL_OVF_CLR_BIT]) ovf_d = 1'b0;
        end
        if (wr_tx && fifo_full) ovf_d = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_tick ? BAUD_RELOAD : baud_cnt_q - 16'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            TX_IDLE: begin
                baud_cnt_d = '0;
                if (enable_q && !fifo_empty && !fifo_flush) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    tx_d       = 1'b0;
                    baud_cnt_d = BAUD_RELOAD;
                    state_d    = TX_START;
                end
            end
            TX_START: if (bit_tick) begin
                tx_d      = shift_q[0];
                bit_idx_d = '0;
                state_d   = TX_DATA;
            end
            TX_DATA: if (bit_tick) begin
                if (bit_idx_q == 3'd7) begin
                    tx_d    = 1'b1;
                    state_d = TX_STOP;
                end else begin
                    shift_d   = shift_q >> 1;
                    tx_d      = shift_q[1];
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            TX_STOP: if (bit_tick) begin
                state_d = TX_IDLE;
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= TX_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            enable_q   <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            enable_q   <= enable_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        status                      = '0;
        status[STAT_BUSY_BIT]       = (state_q != TX_IDLE);
        status[STAT_FULL_BIT]       = fifo_full;
        status[STAT_EMPTY_BIT]      = fifo_empty;
        status[STAT_OVF_BIT]        = ovf_q;
        status[STAT_CNT_LSB +: CW]  = fifo_count;
        bus.sel                     = hit;
        bus.received_data           = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS: bus.received_data = status;
                OFF_CTRL:   bus.received_data[CTRL_EN_BIT] = enable_q;
                default:    bus.received_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at BAUD_DIV=4, FIFO_DEPTH=4; inputs change and outputs sample on the falling edge.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE   = 32'h1001_0100;
    localparam logic [31:0] A_TX   = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CTRL = BASE + 32'h8;

    logic clk = 1'b0;
    logic reset;
    logic tx;
    int   n_chk = 0;
    int   n_err = 0;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(.BASE_ADDR(BASE), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called on a falling edge; the store lands on the next rising edge, returns on the following falling edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.memwrite     = 1'b1;
        bus.data_address = a;
        bus.writedata    = d;
        @(negedge clk);
        bus.memwrite     = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
        bus.data_address = a;
        bus.memread      = 1'b1;
        #1;
        d = bus.received_data;
        s = bus.sel;
        bus.memread = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        s;
        rd(a, d, s);
        check_eq(tag, d, exp);
    endtask

    task automatic rx_byte(output logic [7:0] b);
        int n;
        b = '0;
        n = 0;
        while (tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            check_eq("rx_start_timeout", {63'b0, tx}, 64'd0);
        end else begin
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                b[i] = tx;
            end
            repeat (4) @(negedge clk);
            check_eq("rx_stop_bit", {63'b0, tx}, 64'd1);
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic idle_watch(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        logic [7:0]  b;
        logic [39:0] samp;
        logic [31:0] d;
        logic        s;
        int          lows;
        logic [31:0] addrs [4];
        logic [7:0]  exp3 [4];
        logic [7:0]  exp4 [4];

        addrs = '{32'h1001_0100, 32'h1001_010C, 32'h1001_0102, 32'h1001_0000};
        exp3  = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp4  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};

        reset            = 1'b1;
        bus.memwrite     = 1'b0;
        bus.memread      = 1'b0;
        bus.data_address = '0;
        bus.writedata    = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_tx", {63'b0, tx}, 64'd1);
        chk_reg("rst_status", A_STAT, 32'h0000_0004);
        chk_reg("rst_ctrl", A_CTRL, 32'h0000_0001);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset during the start bit of 0xA5
        wr(A_TX, 32'hA5);
        @(negedge clk);
        check_eq("t1_tx_start_low", {63'b0, tx}, 64'd0);
        reset = 1'b1;
        #1;
        check_eq("t1_tx_async_high", {63'b0, tx}, 64'd1);
        chk_reg("t1_status", A_STAT, 32'h0000_0004);
        chk_reg("t1_ctrl", A_CTRL, 32'h0000_0001);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 2: 0x55 bit-exact waveform, 4 cycles per bit
        wr(A_TX, 32'h55);
        check_eq("t2_tx_before_pop", {63'b0, tx}, 64'd1);
        chk_reg("t2_status_queued", A_STAT, 32'h0000_0100);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            samp[j] = tx;
        end
        check_eq("t2_waveform", {24'b0, samp}, 64'h00_0000_F0F0_F0F0_F0);
        chk_reg("t2_busy_last", A_STAT, 32'h0000_0005);
        @(negedge clk);
        chk_reg("t2_idle_after", A_STAT, 32'h0000_0004);
        check_eq("t2_tx_idle", {63'b0, tx}, 64'd1);

        // 6: decode and side-effect-free loads
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rd(addrs[i], d, s);
            check_eq($sformatf("t6_sel_%0d", i), {63'b0, s}, (i == 0) ? 64'd1 : 64'd0);
            check_eq($sformatf("t6_data_%0d", i), {32'b0, d}, 64'd0);
        end
        @(negedge clk);
        chk_reg("t6_status_unchanged", A_STAT, 32'h0000_0004);

        // 3: disabled fill with overflow, then clear and drain
        wr(A_CTRL, 32'h0);
        wr(A_TX, 32'h11);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h33);
        wr(A_TX, 32'h44);
        wr(A_TX, 32'h99);
        chk_reg("t3_ctrl_off", A_CTRL, 32'h0000_0000);
        chk_reg("t3_status_full_ovf", A_STAT, 32'h0000_040A);
        check_eq("t3_tx_held", {63'b0, tx}, 64'd1);
        wr(A_CTRL, 32'h5);
        chk_reg("t3_status_ovf_clr", A_STAT, 32'h0000_0402);
        for (int i = 0; i < 4; i++) begin
            rx_byte(b);
            check_eq($sformatf("t3_byte_%0d", i), {56'b0, b}, {56'b0, exp3[i]});
        end
        idle_watch(60, lows);
        check_eq("t3_no_fifth", lows, 64'd0);
        chk_reg("t3_status_end", A_STAT, 32'h0000_0004);

        // 4: push to full FIFO on the pop edge is dropped
        wr(A_CTRL, 32'h0);
        wr(A_TX, 32'hC1);
        wr(A_TX, 32'hC2);
        wr(A_TX, 32'hC3);
        wr(A_TX, 32'hC4);
        chk_reg("t4_status_full", A_STAT, 32'h0000_0402);
        wr(A_CTRL, 32'h1);
        wr(A_TX, 32'hEE);
        chk_reg("t4_status_race", A_STAT, 32'h0000_0309);
        for (int i = 0; i < 4; i++) begin
            rx_byte(b);
            check_eq($sformatf("t4_byte_%0d", i), {56'b0, b}, {56'b0, exp4[i]});
        end
        chk_reg("t4_status_drained", A_STAT, 32'h0000_000C);
        wr(A_CTRL, 32'h5);
        chk_reg("t4_status_cleared", A_STAT, 32'h0000_0004);

        // 5: flush during first frame keeps the frame, discards the queued byte
        wr(A_TX, 32'h41);
        wr(A_TX, 32'h42);
        chk_reg("t5_status_one_queued", A_STAT, 32'h0000_0101);
        wr(A_CTRL, 32'h3);
        chk_reg("t5_status_flushed", A_STAT, 32'h0000_0005);
        rx_byte(b);
        check_eq("t5_byte_41", {56'b0, b}, 64'h41);
        idle_watch(60, lows);
        check_eq("t5_no_42", lows, 64'd0);
        chk_reg("t5_status_end", A_STAT, 32'h0000_0004);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
